// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: opcodes, IR field positions,
// FSM state encoding and opcode classification.
package control_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RA_HI  = 26;
    localparam int unsigned RA_LO  = 23;
    localparam int unsigned RB_HI  = 22;
    localparam int unsigned RB_LO  = 19;
    localparam int unsigned RC_HI  = 18;
    localparam int unsigned RC_LO  = 15;

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StDec, StT3, StT4, StT5, StT6, StT7, StHalt, StFault
    } state_t;

    typedef enum logic [2:0] {
        ClsAlu, ClsMd, ClsNop, ClsHalt, ClsIllegal
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return ClsAlu;
            OP_MUL, OP_DIV:                return ClsMd;
            OP_NOP:                        return ClsNop;
            OP_HALT:                       return ClsHalt;
            default:                       return ClsIllegal;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_dec_4_16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module dec_4_16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired multi-cycle control unit: fetch with memory-ready timeout, then
// executes ALU, mul/div, nop and halt by driving datapath strobes.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TCNT_W      = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  operation,
    output logic        run,
    output logic        fault
);

    localparam logic [TCNT_W-1:0] WaitLast = TCNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q;
    logic [TCNT_W-1:0] wait_cnt_q;

    op_class_t  cls;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       rin_en, rout_en;
    logic [3:0] rin_sel, rout_sel;
    logic       unused_ir;

    assign opcode    = ir[OPC_HI:OPC_LO];
    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign rc        = ir[RC_HI:RC_LO];
    assign cls       = op_class(opcode);
    assign unused_ir = ^ir[RC_LO-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= StRst;
            wait_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRst: state_q <= StT0;
                StT0: begin
                    wait_cnt_q <= '0;
                    state_q    <= StT1;
                end
                StT1: begin
                    // A ready on the final counted cycle still wins over the timeout.
                    if (mem_ready) begin
                        state_q <= StT2;
                    end else if (wait_cnt_q >= WaitLast) begin
                        state_q <= StFault;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StT2: state_q <= StDec;
                StDec: begin
                    case (cls)
                        ClsAlu, ClsMd: state_q <= StT3;
                        ClsNop:        state_q <= StT0;
                        ClsHalt:       state_q <= StHalt;
                        default:       state_q <= StFault;
                    endcase
                end
                StT3: state_q <= StT4;
                StT4: state_q <= (cls == ClsMd) ? StT6 : StT5;
                StT5: state_q <= StT0;
                StT6: state_q <= StT7;
                StT7: state_q <= StT0;
                StHalt: state_q <= StHalt;
                StFault: state_q <= StFault;
                default: state_q <= StFault;
            endcase
        end
    end

    always_comb begin
        {PCout, Zlowout, ZHighout, MDRout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin} = '0;
        {IncPC, Read} = '0;
        operation = 5'b00000;
        run       = 1'b0;
        fault     = 1'b0;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rin_sel   = ra;
        rout_sel  = rb;
        unique case (state_q)
            StT0: begin
                {PCout, MARin, IncPC, ZLOin, run} = '1;
            end
            StT1: begin
                {Zlowout, Read, run} = '1;
                PCin  = mem_ready;
                MDRin = mem_ready;
            end
            StT2: {MDRout, IRin, run} = '1;
            StDec: run = 1'b1;
            StT3: begin
                {Yin, run} = '1;
                rout_en  = 1'b1;
                rout_sel = (cls == ClsMd) ? ra : rb;
            end
            StT4: begin
                {ZHIin, ZLOin, run} = '1;
                operation = opcode;
                rout_en   = 1'b1;
                rout_sel  = (cls == ClsMd) ? rb : rc;
            end
            StT5: begin
                {Zlowout, run} = '1;
                rin_en = 1'b1;
            end
            StT6: {Zlowout, LOin, run} = '1;
            StT7: {ZHighout, HIin, run} = '1;
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

    dec_4_16 u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    dec_4_16 u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected output traces built from the
// phase rules of each opcode class, compared cycle by cycle against the DUT.
module tb_control_sequencer;

    localparam int unsigned TMO = 15;

    typedef struct packed {
        logic        pc_out, zlow_out, zhigh_out, mdr_out;
        logic        mar_in, pc_in, mdr_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in;
        logic        inc_pc, read;
        logic [15:0] rin, rout;
        logic [4:0]  op;
        logic        run, fault;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic        PCout, Zlowout, ZHighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin;
    logic        IncPC, Read, run, fault;
    logic [15:0] Rin, Rout;
    logic [4:0]  operation;
    ctl_t        obs;

    int checks   = 0;
    int failures = 0;

    ctl_t        exp_q[$];
    logic        rdy_q[$];
    logic [31:0] ir_q[$];
    string       ph_q[$];

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(TMO), .TCNT_W(8)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .ZHIin(ZHIin), .ZLOin(ZLOin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout),
        .operation(operation), .run(run), .fault(fault)
    );

    assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZHIin,
                  ZLOin, HIin, LOin, IncPC, Read, Rin, Rout, operation, run, fault};

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] f);
        return 16'h0001 << f;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'($urandom)};
    endfunction

    function automatic bit is_md(input logic [4:0] opc);
        return opc == 5'b01111 || opc == 5'b10000;
    endfunction

    function automatic bit is_alu(input logic [4:0] opc);
        return opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    endfunction

    // Expected output vector for one named phase of an instruction.
    function automatic ctl_t row(input string ph, input logic [31:0] i, input logic rdy);
        ctl_t c;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        c   = '0;
        opc = i[31:27];
        ra  = i[26:23];
        rb  = i[22:19];
        rc  = i[18:15];
        c.run = (ph != "HALT" && ph != "FAULT");
        case (ph)
            "T0": begin c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.zlo_in = 1; end
            "T1": begin c.zlow_out = 1; c.read = 1; c.pc_in = rdy; c.mdr_in = rdy; end
            "T2": begin c.mdr_out = 1; c.ir_in = 1; end
            "T3": begin c.y_in = 1; c.rout = is_md(opc) ? oh(ra) : oh(rb); end
            "T4": begin
                c.zhi_in = 1; c.zlo_in = 1; c.op = opc;
                c.rout = is_md(opc) ? oh(rb) : oh(rc);
            end
            "T5": begin c.zlow_out = 1; c.rin = oh(ra); end
            "T6": begin c.zlow_out = 1; c.lo_in = 1; end
            "T7": begin c.zhigh_out = 1; c.hi_in = 1; end
            "FAULT": c.fault = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic push(input string ph, input logic [31:0] i, input logic rdy);
        exp_q.push_back(row(ph, i, rdy));
        rdy_q.push_back(rdy);
        ir_q.push_back(i);
        ph_q.push_back(ph);
    endtask

    // Queue the whole phase sequence of one instruction; w = idle cycles before ready.
    task automatic add_instr(input logic [31:0] i, input int w);
        logic [4:0] opc;
        opc = i[31:27];
        push("T0", i, rnd());
        if (w >= int'(TMO)) begin
            for (int k = 0; k < int'(TMO); k++) push("T1", i, 1'b0);
            push("FAULT", i, rnd());
            return;
        end
        for (int k = 0; k < w; k++) push("T1", i, 1'b0);
        push("T1", i, 1'b1);
        push("T2", i, rnd());
        push("DEC", i, rnd());
        if (is_alu(opc)) begin
            push("T3", i, rnd()); push("T4", i, rnd()); push("T5", i, rnd());
        end else if (is_md(opc)) begin
            push("T3", i, rnd()); push("T4", i, rnd());
            push("T6", i, rnd()); push("T7", i, rnd());
        end else if (opc == 5'b11010) begin
        end else if (opc == 5'b11011) begin
            push("HALT", i, rnd());
        end else begin
            push("FAULT", i, rnd());
        end
    endtask

    task automatic hold(input string ph, input int n);
        for (int k = 0; k < n; k++) push(ph, 32'($urandom), rnd());
    endtask

    // Play up to n queued cycles (n < 0: all), comparing at the falling edge.
    task automatic play(input int n);
        int    k;
        ctl_t  e;
        string ph;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            e  = exp_q.pop_front();
            ph = ph_q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = rdy_q.pop_front();
            ir        = ir_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL phase %s ir=%h: got %h want %h", ph, ir, obs, e);
            end
            k++;
        end
    endtask

    task automatic flush();
        exp_q.delete(); rdy_q.delete(); ir_q.delete(); ph_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 1'b0;
        #1;
        checks++;
        if (obs !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        flush();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_hold: got %h want 0", obs);
        end
        mem_ready = 1'b0;
        clr = 1'b1;
    endtask

    task automatic test_alu_fixed();
        add_instr(32'h18A9_8000, 0);
        play(-1);
    endtask

    task automatic test_mul();
        add_instr(mk_ir(5'b01111, 4'd2, 4'd4, 4'd9), 0);
        add_instr(mk_ir(5'b10000, 4'd0, 4'd15, 4'd1), 3);
        play(-1);
    endtask

    task automatic test_random();
        logic [4:0] alu_ops[4];
        logic [4:0] opc;
        alu_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110};
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: opc = alu_ops[$urandom_range(0, 3)];
                1: opc = ($urandom_range(0, 1) == 0) ? 5'b01111 : 5'b10000;
                default: opc = 5'b11010;
            endcase
            add_instr(mk_ir(opc, 4'($urandom), 4'($urandom), 4'($urandom)),
                      $urandom_range(0, TMO - 1));
        end
        play(-1);
    endtask

    task automatic test_ready_at_timeout();
        add_instr(mk_ir(5'b00100, 4'd0, 4'd7, 4'd12), TMO - 1);
        play(-1);
    endtask

    task automatic test_timeout();
        add_instr(mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), TMO);
        hold("FAULT", 5);
        play(-1);
    endtask

    task automatic test_halt();
        add_instr(mk_ir(5'b11011, 4'($urandom), 4'($urandom), 4'($urandom)), 2);
        hold("HALT", 19);
        play(-1);
    endtask

    task automatic test_illegal(input logic [4:0] opc);
        add_instr(mk_ir(opc, 4'd5, 4'd6, 4'd7), 1);
        hold("FAULT", 4);
        play(-1);
    endtask

    task automatic test_reset_mid();
        add_instr(mk_ir(5'b00101, 4'd9, 4'd10, 4'd11), 0);
        play(6);
        clr = 1'b0;
        #1;
        checks++;
        if (obs !== ctl_t'(0)) begin
            failures++;
            $display("FAIL reset_mid_t4: got %h want 0", obs);
        end
        flush();
        @(negedge clk);
        mem_ready = 1'b0;
        clr = 1'b1;
        add_instr(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0);
        play(-1);
    endtask

    initial begin
        logic [4:0] bad;
        test_reset();
        test_alu_fixed();
        test_mul();
        test_random();
        test_ready_at_timeout();
        test_timeout();
        test_reset();
        test_halt();
        test_reset();
        test_illegal(5'b11111);
        test_reset();
        do bad = 5'($urandom);
        while (is_alu(bad) || is_md(bad) || bad == 5'b11010 || bad == 5'b11011);
        test_illegal(bad);
        test_reset();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
